uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/tx_stall_timer.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents:
//   arb_state_t  - arbiter state encoding (IDLE / OWN0 / OWN1), which doubles
//                  as the one-hot grant vector
//   REQ0, REQ1   - requester index constants, used for the last_owner bit
//   owner_index  - maps an owning state to its requester index
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    function automatic logic owner_index(input arb_state_t st);
        return (st == OWN1) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/tx_stall_timer.sv
// Saturating idle-cycle counter for the arbiter's stall timeout.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   clear     - zero the count (takes priority over inc)
//   inc       - count one more idle cycle, stopping at LIMIT
//   expired   - count has reached LIMIT
module tx_stall_timer #(
    parameter int unsigned LIMIT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] count;

    // Saturate at LIMIT so a long stall can never wrap back to a small value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != LIMIT_V)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LIMIT_V);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester, packet-granular arbiter in front of a UART transmit FIFO.
// A requester owns the FIFO for a whole packet (until it offers a byte with
// last set), so bytes of different packets never interleave. Ties in IDLE are
// broken round-robin. An owner that stops offering bytes for STALL_TIMEOUT
// cycles loses its grant.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   reqN_valid/data/last/ready       - byte handshake for requester N (0, 1)
//   tx_full                          - UART transmit FIFO is full
//   wr_uart, w_data                  - FIFO write strobe and byte
//   grant                            - one-hot owner, 00 when idle
//   timeout_evt                      - one-cycle pulse on a stall revocation
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic [1:0] grant,
    output logic       timeout_evt
);

    arb_state_t state, state_next;
    logic       last_owner, last_owner_next;
    logic       owner_valid, owner_last, transfer;
    logic       stall_clear, stall_expired;

    // State and last_owner registers. last_owner resets to REQ1 so that the
    // first contended arbitration after reset favours requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= REQ1;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
        end
    end

    // Datapath mux: only the owner sees ready, and the FIFO sees only the
    // owner's byte. Readies stay low in IDLE, which costs the one-cycle
    // arbitration slot.
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        w_data      = 8'h00;
        case (state)
            OWN0: begin
                req0_ready  = !tx_full;
                owner_valid = req0_valid;
                owner_last  = req0_last;
                w_data      = req0_data;
            end
            OWN1: begin
                req1_ready  = !tx_full;
                owner_valid = req1_valid;
                owner_last  = req1_last;
                w_data      = req1_data;
            end
            default: ;
        endcase
    end

    assign transfer    = owner_valid && (req0_ready || req1_ready);
    assign wr_uart     = transfer;
    assign grant       = state;
    assign timeout_evt = (state != IDLE) && stall_expired;

    // Next-state logic. A packet ends either on a transfer of its last byte
    // or on a stall timeout; both hand priority to the other requester.
    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_next = (last_owner == REQ0) ? OWN1 : OWN0;
                end else if (req0_valid) begin
                    state_next = OWN0;
                end else if (req1_valid) begin
                    state_next = OWN1;
                end
            end
            OWN0, OWN1: begin
                if ((transfer && owner_last) || stall_expired) begin
                    state_next      = IDLE;
                    last_owner_next = owner_index(state);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The counter sits at zero through IDLE so every grant starts fresh. Any
    // cycle with the owner's valid high clears it, so tx_full backpressure
    // with a byte pending never counts as a stall.
    assign stall_clear = (state == IDLE) || owner_valid;

    tx_stall_timer #(
        .LIMIT(STALL_TIMEOUT)
    ) u_stall_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (stall_clear),
        .inc    (!stall_clear),
        .expired(stall_expired)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (STALL_TIMEOUT = 4).
// Requesters are modelled as byte queues that hold their head byte until it
// is accepted. Each test pushes the bytes it expects on the FIFO side into a
// scoreboard queue; every write strobe seen pops and compares one entry.
module tb_uart_tx_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [1:0] grant;
    logic       timeout_evt;

    int errors = 0;
    int checks = 0;

    // Requester byte queues: {last, data}; tx_full plan: one entry per cycle.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       full_q[$];
    // Scoreboard entries: {grant, data} expected on each FIFO write.
    logic [9:0] exp_q[$];

    logic fire0 = 1'b0;
    logic fire1 = 1'b0;

    uart_tx_arbiter #(
        .STALL_TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .tx_full    (tx_full),
        .wr_uart    (wr_uart),
        .w_data     (w_data),
        .grant      (grant),
        .timeout_evt(timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record handshakes mid-cycle, when all inputs are settled.
    always @(negedge clk) begin
        fire0 = req0_valid && req0_ready;
        fire1 = req1_valid && req1_ready;
    end

    // Requester and tx_full drivers: just after each rising edge, retire an
    // accepted byte and present the next queue head.
    always @(posedge clk) begin
        #1;
        if (fire0 && q0.size() > 0) q0.delete(0);
        if (fire1 && q1.size() > 0) q1.delete(0);
        req0_valid = (q0.size() > 0);
        req0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        req0_last  = (q0.size() > 0) ? q0[0][8] : 1'b0;
        req1_valid = (q1.size() > 0);
        req1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        req1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
        if (full_q.size() > 0) tx_full = full_q.pop_front();
        else                   tx_full = 1'b0;
    end

    // Compare any FIFO write in the current cycle against the scoreboard.
    task automatic sample_writes();
        logic [9:0] exp;
        if (wr_uart === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got grant=%b data=%h, required no write", grant, w_data);
            end else begin
                exp = exp_q.pop_front();
                if ({grant, w_data} !== exp) begin
                    errors++;
                    $display("[TB] FAIL write_data: got grant=%b data=%h, required grant=%b data=%h",
                             grant, w_data, exp[9:8], exp[7:0]);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample_writes();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        full_q.delete();
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: got %0d bytes unwritten, required 0", name, exp_q.size());
        end
    endtask

    // Outputs must stay quiet while reset is held, even with both valids up.
    task automatic test_reset();
        @(negedge clk);
        q0.push_back({1'b1, 8'h33});
        q1.push_back({1'b1, 8'h44});
        @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (grant !== 2'b00)       begin errors++; $display("[TB] FAIL reset_grant: got %b required 00", grant); end
        if (wr_uart !== 1'b0)      begin errors++; $display("[TB] FAIL reset_wr: got %b required 0", wr_uart); end
        if (w_data !== 8'h00)      begin errors++; $display("[TB] FAIL reset_wdata: got %h required 00", w_data); end
        if (req0_ready !== 1'b0)   begin errors++; $display("[TB] FAIL reset_ready0: got %b required 0", req0_ready); end
        if (req1_ready !== 1'b0)   begin errors++; $display("[TB] FAIL reset_ready1: got %b required 0", req1_ready); end
        if (timeout_evt !== 1'b0)  begin errors++; $display("[TB] FAIL reset_timeout: got %b required 0", timeout_evt); end
        q0.delete();
        q1.delete();
        do_reset();
    endtask

    // req0 sends 41,42,43: one arbitration cycle, then three back-to-back writes.
    task automatic test_single_packet();
        logic [1:0] g_exp [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        logic       w_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks += 2;
            if (grant !== g_exp[i])   begin errors++; $display("[TB] FAIL single_grant[%0d]: got %b required %b", i, grant, g_exp[i]); end
            if (wr_uart !== w_exp[i]) begin errors++; $display("[TB] FAIL single_wr[%0d]: got %b required %b", i, wr_uart, w_exp[i]); end
            if (i == 0) begin
                q0.push_back({1'b0, 8'h41}); exp_q.push_back({2'b01, 8'h41});
                q0.push_back({1'b0, 8'h42}); exp_q.push_back({2'b01, 8'h42});
                q0.push_back({1'b1, 8'h43}); exp_q.push_back({2'b01, 8'h43});
            end
        end
        check_drained("single");
    endtask

    // Both valid in IDLE right after reset: req0 first, then req1.
    task automatic test_round_robin();
        logic [1:0] g_exp [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (grant !== g_exp[i]) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %b required %b", i, grant, g_exp[i]); end
            if (i == 0) begin
                q0.push_back({1'b1, 8'hAA}); exp_q.push_back({2'b01, 8'hAA});
                q1.push_back({1'b1, 8'h55}); exp_q.push_back({2'b10, 8'h55});
            end
        end
        check_drained("rr");
    endtask

    // req1 owns a two-byte packet while req0 waits with a byte pending.
    task automatic test_no_interleave();
        logic [1:0] g_exp [7] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
        logic       r_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            checks += 2;
            if (grant !== g_exp[i])      begin errors++; $display("[TB] FAIL inter_grant[%0d]: got %b required %b", i, grant, g_exp[i]); end
            if (req0_ready !== r_exp[i]) begin errors++; $display("[TB] FAIL inter_ready0[%0d]: got %b required %b", i, req0_ready, r_exp[i]); end
            if (i == 0) begin
                q1.push_back({1'b0, 8'h10}); exp_q.push_back({2'b10, 8'h10});
                q1.push_back({1'b1, 8'h11}); exp_q.push_back({2'b10, 8'h11});
            end
            if (i == 1) begin
                q0.push_back({1'b1, 8'h20}); exp_q.push_back({2'b01, 8'h20});
            end
        end
        check_drained("inter");
    endtask

    // tx_full for five cycles mid-packet: writes pause, no stall, no loss.
    task automatic test_backpressure();
        logic w_exp [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic r_exp [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            tick();
            checks += 3;
            if (wr_uart !== w_exp[i])    begin errors++; $display("[TB] FAIL bp_wr[%0d]: got %b required %b", i, wr_uart, w_exp[i]); end
            if (req0_ready !== r_exp[i]) begin errors++; $display("[TB] FAIL bp_ready0[%0d]: got %b required %b", i, req0_ready, r_exp[i]); end
            if (timeout_evt !== 1'b0)    begin errors++; $display("[TB] FAIL bp_timeout[%0d]: got %b required 0", i, timeout_evt); end
            if (i == 0) begin
                q0.push_back({1'b0, 8'h01}); exp_q.push_back({2'b01, 8'h01});
                q0.push_back({1'b0, 8'h02}); exp_q.push_back({2'b01, 8'h02});
                q0.push_back({1'b1, 8'h03}); exp_q.push_back({2'b01, 8'h03});
            end
            if (i == 2) begin
                for (int k = 0; k < 5; k++) full_q.push_back(1'b1);
            end
        end
        check_drained("bp");
    endtask

    // req0 goes silent mid-packet: revoked after 4 idle cycles, req1 next.
    task automatic test_timeout();
        logic [1:0] g_exp [12] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01,
                                   2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick();
            checks += 2;
            if (grant !== g_exp[i]) begin errors++; $display("[TB] FAIL to_grant[%0d]: got %b required %b", i, grant, g_exp[i]); end
            if (timeout_evt !== (i == 8)) begin
                errors++;
                $display("[TB] FAIL to_evt[%0d]: got %b required %b", i, timeout_evt, (i == 8));
            end
            if (i == 0) begin
                q0.push_back({1'b0, 8'h61}); exp_q.push_back({2'b01, 8'h61});
                q0.push_back({1'b0, 8'h62}); exp_q.push_back({2'b01, 8'h62});
            end
            if (i == 3) begin
                q1.push_back({1'b1, 8'h70}); exp_q.push_back({2'b10, 8'h70});
            end
        end
        check_drained("to");
    endtask

    // Reset lands during the second byte of a four-byte packet.
    task automatic test_reset_mid_packet();
        logic [1:0] g_exp [3] = '{2'b00, 2'b00, 2'b01};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (grant !== g_exp[i]) begin errors++; $display("[TB] FAIL rstmid_grant[%0d]: got %b required %b", i, grant, g_exp[i]); end
            if (i == 0) begin
                q0.push_back({1'b0, 8'h81}); exp_q.push_back({2'b01, 8'h81});
                q0.push_back({1'b0, 8'h82});
                q0.push_back({1'b0, 8'h83});
                q0.push_back({1'b1, 8'h84});
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        q0.delete();
        tick();
        checks += 3;
        if (wr_uart !== 1'b0)    begin errors++; $display("[TB] FAIL rstmid_wr: got %b required 0", wr_uart); end
        if (grant !== 2'b00)     begin errors++; $display("[TB] FAIL rstmid_grant: got %b required 00", grant); end
        if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ready0: got %b required 0", req0_ready); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks += 2;
            if (wr_uart !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_after_wr[%0d]: got %b required 0", i, wr_uart); end
            if (grant !== 2'b00)  begin errors++; $display("[TB] FAIL rstmid_after_grant[%0d]: got %b required 00", i, grant); end
        end
        check_drained("rstmid");
    endtask

    initial begin
        rst        = 1'b1;
        tx_full    = 1'b0;
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req0_last  = 1'b0;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        req1_last  = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_no_interleave();
        test_backpressure();
        test_timeout();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
